// File: rtl/demux_pkg.sv
// Shared lane/select definitions for the 1-to-4 demultiplexer.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] lane_sel_t;

    function automatic logic [NUM_LANES-1:0] decode_sel(input lane_sel_t s);
        decode_sel = {{(NUM_LANES-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane: registered data/valid that drop to zero when not hit.
// DEMUX_1TO4_CNT_EN adds a saturating delivery counter.
module demux_lane_reg #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hit_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
`ifdef DEMUX_1TO4_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_o
`endif
);

    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    // Next lane contents: data only when this lane is the current target.
    always_comb begin
        data_d  = {DATA_W{1'b0}};
        valid_d = 1'b0;
        if (hit_i) begin
            data_d  = din_i;
            valid_d = 1'b1;
        end else begin
            data_d  = {DATA_W{1'b0}};
            valid_d = 1'b0;
        end
    end

    // Lane data/valid register; reset wins over any transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

`ifdef DEMUX_1TO4_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Saturating count of deliveries; holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (hit_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
`endif

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer with one-hot lane valid.
// Optional per-lane delivery counters under DEMUX_1TO4_CNT_EN.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             din,
    input  lane_sel_t                     sel,
    input  logic                          in_valid,
    output logic [NUM_LANES*DATA_W-1:0]   y,
    output logic [NUM_LANES-1:0]          out_valid
`ifdef DEMUX_1TO4_CNT_EN
    ,
    output logic [NUM_LANES*CNT_W-1:0]    lane_cnt
`endif
);

    logic [NUM_LANES-1:0] hit_s;
    logic [NUM_LANES-1:0] valid_q;

    assign hit_s = in_valid ? decode_sel(sel) : {NUM_LANES{1'b0}};

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
`ifdef DEMUX_1TO4_CNT_EN
        demux_lane_reg #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk_i   (clk),
            .rst_i   (rst),
            .hit_i   (hit_s[k]),
            .din_i   (din),
            .data_o  (y[k*DATA_W +: DATA_W]),
            .valid_o (valid_q[k]),
            .cnt_o   (lane_cnt[k*CNT_W +: CNT_W])
        );
`else
        demux_lane_reg #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk_i   (clk),
            .rst_i   (rst),
            .hit_i   (hit_s[k]),
            .din_i   (din),
            .data_o  (y[k*DATA_W +: DATA_W]),
            .valid_o (valid_q[k])
        );
`endif
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench: DATA_W=1 and DATA_W=8 instances driven side by side.
module tb_demux_1to4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  sel;
    logic        din1;
    logic [7:0]  din8;
    logic [3:0]  y1;
    logic [31:0] y8;
    logic [3:0]  ov1, ov8;
`ifdef DEMUX_1TO4_CNT_EN
    logic [63:0] cnt1;
    logic [7:0]  cnt8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [3:0]  exp_y1, exp_ov;
    logic [31:0] exp_y8;
    int          m_cnt1 [4];
    int          m_cnt8 [4];
    bit          have_prev = 1'b0;

    always #5 clk = ~clk;

    demux_1to4 #(.DATA_W(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .sel(sel), .in_valid(in_valid),
        .y(y1), .out_valid(ov1)
`ifdef DEMUX_1TO4_CNT_EN
        , .lane_cnt(cnt1)
`endif
    );

    demux_1to4 #(.DATA_W(8), .CNT_W(2)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .sel(sel), .in_valid(in_valid),
        .y(y8), .out_valid(ov8)
`ifdef DEMUX_1TO4_CNT_EN
        , .lane_cnt(cnt8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance past the edge, update model, compare.
    task automatic step(input bit r, input bit v, input logic [1:0] s,
                        input logic d1, input logic [7:0] d8);
        rst = r; in_valid = v; sel = s; din1 = d1; din8 = d8;
        #1;
        if (have_prev) begin
            check("hold_y8", {32'd0, y8}, {32'd0, exp_y8});
            check("hold_ov1", {60'd0, ov1}, {60'd0, exp_ov});
        end
        @(posedge clk);
        if (r) begin
            exp_y1 = 4'd0; exp_y8 = 32'd0; exp_ov = 4'd0;
            for (int k = 0; k < 4; k++) begin m_cnt1[k] = 0; m_cnt8[k] = 0; end
        end else if (v) begin
            exp_ov = 4'd1 << s;
            exp_y1 = d1 ? exp_ov : 4'd0;
            exp_y8 = {24'd0, d8} << (8 * int'(s));
            if (m_cnt1[s] < 65535) m_cnt1[s]++;
            if (m_cnt8[s] < 3)     m_cnt8[s]++;
        end else begin
            exp_y1 = 4'd0; exp_y8 = 32'd0; exp_ov = 4'd0;
        end
        have_prev = 1'b1;
        #1;
        check("y1", {60'd0, y1}, {60'd0, exp_y1});
        check("y8", {32'd0, y8}, {32'd0, exp_y8});
        check("ov1", {60'd0, ov1}, {60'd0, exp_ov});
        check("ov8", {60'd0, ov8}, {60'd0, exp_ov});
`ifdef DEMUX_1TO4_CNT_EN
        for (int k = 0; k < 4; k++) begin
            check("cnt1", {48'd0, cnt1[k*16 +: 16]}, 64'(m_cnt1[k]));
            check("cnt8", {62'd0, cnt8[k*2 +: 2]}, 64'(m_cnt8[k]));
        end
`endif
    endtask

    typedef struct {
        bit          r;
        bit          v;
        logic [1:0]  s;
        logic        d1;
        logic [7:0]  d8;
        logic [3:0]  ey1;
        logic [31:0] ey8;
        logic [3:0]  eov;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 2'd1, 1'b1, 8'hFF, 4'b0000, 32'h0000_0000, 4'b0000};
        tbl[1] = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 32'h0000_0011, 4'b0001};
        tbl[2] = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h22, 4'b0010, 32'h0000_2200, 4'b0010};
        tbl[3] = '{1'b0, 1'b1, 2'd2, 1'b1, 8'h33, 4'b0100, 32'h0033_0000, 4'b0100};
        tbl[4] = '{1'b0, 1'b1, 2'd3, 1'b1, 8'hA5, 4'b1000, 32'hA500_0000, 4'b1000};
        tbl[5] = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h3C, 4'b0001, 32'h0000_003C, 4'b0001};
        tbl[6] = '{1'b0, 1'b0, 2'd2, 1'b1, 8'h77, 4'b0000, 32'h0000_0000, 4'b0000};
        tbl[7] = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 4'b0000, 32'h0000_0000, 4'b0100};
        tbl[8] = '{1'b1, 1'b1, 2'd1, 1'b1, 8'h5A, 4'b0000, 32'h0000_0000, 4'b0000};
        tbl[9] = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h5A, 4'b0010, 32'h0000_5A00, 4'b0010};

        for (int k = 0; k < 4; k++) begin m_cnt1[k] = 0; m_cnt8[k] = 0; end
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d1, tbl[i].d8);
            check("tbl_y1", {60'd0, y1}, {60'd0, tbl[i].ey1});
            check("tbl_y8", {32'd0, y8}, {32'd0, tbl[i].ey8});
            check("tbl_ov", {60'd0, ov8}, {60'd0, tbl[i].eov});
        end

        // counter corner case: 5x lane 2 + 1x lane 0, and 6x lane 1 on the narrow counters
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd2, 1'b1, 8'h01);
        step(1'b0, 1'b1, 2'd0, 1'b1, 8'h02);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd1, 1'b0, 8'h03);
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
`ifdef DEMUX_1TO4_CNT_EN
        check("cnt_lane2", {48'd0, cnt1[47:32]}, 64'd5);
        check("cnt_lane0", {48'd0, cnt1[15:0]},  64'd1);
        check("cnt_lane3", {48'd0, cnt1[63:48]}, 64'd0);
        check("cnt_sat_lane1", {62'd0, cnt8[3:2]}, 64'd3);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
